// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;
endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - flop-chain synchronizer for an asynchronous input, resets high
module uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with framing-error, overrun and false-start handling
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [15:0]               bauddiv_i,
  input  logic                      rx_i,
  input  logic                      rx_full_i,
  output logic [UART_DATA_BITS-1:0] rx_byte_o,
  output logic                      rx_enqueue_o,
  output logic                      frame_err_o,
  output logic                      overrun_o,
  output logic                      rx_busy_o
);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_rx_state_t            state;
  logic [15:0]               cnt;
  logic [2:0]                bitcnt;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      rx_s;
  logic                      line_prev;
  logic                      tick;

  uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock  (clock),
    .resetn (resetn),
    .d      (rx_i),
    .q      (rx_s)
  );

  assign tick      = (cnt == 16'd0);
  assign rx_busy_o = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= 16'd0;
      bitcnt       <= 3'd0;
      shreg        <= '0;
      line_prev    <= 1'b1;
      rx_byte_o    <= '0;
      rx_enqueue_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      rx_enqueue_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
      line_prev    <= rx_s;
      if (!tick) begin
        cnt <= cnt - 16'd1;
      end
      case (state)
        IDLE: begin
          // Only a 1->0 edge starts a frame, so a held-low break cannot retrigger.
          if (line_prev && !rx_s) begin
            state <= START;
            cnt   <= bauddiv_i >> 1;
          end
        end
        START: begin
          if (tick) begin
            if (!rx_s) begin
              state  <= DATA;
              cnt    <= bauddiv_i;
              bitcnt <= 3'd0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shreg  <= {rx_s, shreg[UART_DATA_BITS-1:1]};
            cnt    <= bauddiv_i;
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == LAST_BIT) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          // Leave mid stop bit so the next start edge is caught with half a bit of margin.
          if (tick) begin
            state <= IDLE;
            if (rx_s) begin
              if (!rx_full_i) begin
                rx_byte_o    <= shreg;
                rx_enqueue_o <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
            end else begin
              frame_err_o <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
